// File: rtl/serial_link_rx_fifo_if.sv
// AXI-lite write channel plus OBI reader port of serial_link_rx_fifo.
// Signal names keep their _i/_o suffixes as seen from the FIFO, which uses the slave modport.
interface serial_link_rx_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic                    w_valid_i;
  logic                    w_ready_o;
  logic [DATA_WIDTH-1:0]   w_data_i;
  logic [DATA_WIDTH/8-1:0] w_strb_i;
  logic                    b_valid_o;
  logic                    b_ready_i;
  logic [1:0]              b_resp_o;
  logic                    obi_req_i;
  logic                    obi_we_i;
  logic [ADDR_WIDTH-1:0]   obi_addr_i;
  logic [DATA_WIDTH/8-1:0] obi_be_i;
  logic [DATA_WIDTH-1:0]   obi_wdata_i;
  logic                    obi_gnt_o;
  logic                    obi_rvalid_o;
  logic [DATA_WIDTH-1:0]   obi_rdata_o;

  modport slave (
    input  aw_valid_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
           obi_req_i, obi_we_i, obi_addr_i, obi_be_i, obi_wdata_i,
    output aw_ready_o, w_ready_o, b_valid_o, b_resp_o,
           obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );

  modport master (
    output aw_valid_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
           obi_req_i, obi_we_i, obi_addr_i, obi_be_i, obi_wdata_i,
    input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o,
           obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );
endinterface

// File: rtl/serial_link_rx_fifo.sv
// RX FIFO: AXI-lite writes push, OBI reads pop DATA (rvalid 1 cycle after grant, data readable 1 cycle after push).
// aw/w ready drop while full or a B response is pending; SERIAL_LINK_RX_FIFO_IRQ_EN adds the THRESH level irq.
module serial_link_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  serial_link_rx_fifo_if.slave bus,
  output logic                 irq_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                r_state;
  logic                  r_b_valid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_set;
  logic                  w_clr;
  logic                  w_obi_rd;
  logic                  w_obi_wr;
  logic [1:0]            w_reg;
  logic [15:0]           w_thresh;
  logic [DATA_WIDTH-1:0] w_push_dat;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  w_unused;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // Ready is gated by rst_ni so the writer sees no acceptance while reset is held.
  assign w_wr_rdy  = rst_ni && (r_state == S_IDLE) && !w_full;
  assign w_push    = w_wr_rdy && bus.aw_valid_i && bus.w_valid_i;
  assign w_ovf_set = bus.aw_valid_i && bus.w_valid_i && w_full;

  assign w_reg     = bus.obi_addr_i[3:2];
  assign w_obi_rd  = bus.obi_req_i && !bus.obi_we_i;
  assign w_obi_wr  = bus.obi_req_i && bus.obi_we_i;
  assign w_pop     = w_obi_rd && (w_reg == 2'd0) && !w_empty;
  assign w_clr     = w_obi_wr && (w_reg == 2'd3) && (|bus.obi_be_i);

  assign bus.aw_ready_o   = w_wr_rdy;
  assign bus.w_ready_o    = w_wr_rdy;
  assign bus.b_valid_o    = r_b_valid;
  assign bus.b_resp_o     = 2'b00;
  assign bus.obi_gnt_o    = bus.obi_req_i;
  assign bus.obi_rvalid_o = r_rvalid;
  assign bus.obi_rdata_o  = r_rdata;

  always_comb begin
    w_push_dat = '0;
    for (int b = 0; b < SW; b++) begin
      if (bus.w_strb_i[b]) w_push_dat[8*b +: 8] = bus.w_data_i[8*b +: 8];
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_empty;
    w_status[1]       = w_full;
    w_status[2]       = r_ovf;
    w_status[8 +: CW] = r_count;
  end

  // Writes and empty DATA reads return zero.
  always_comb begin
    w_rdata_nxt = '0;
    if (w_obi_rd) begin
      case (w_reg)
        2'd0:    if (!w_empty) w_rdata_nxt = r_mem[r_rptr];
        2'd1:    w_rdata_nxt = w_status;
        2'd2:    w_rdata_nxt[15:0] = w_thresh;
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_b_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_push) begin
          r_state   <= S_RESP;
          r_b_valid <= 1'b1;
        end
        S_RESP: if (bus.b_ready_i) begin
          r_state   <= S_IDLE;
          r_b_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_rvalid <= bus.obi_req_i;
      r_rdata  <= w_rdata_nxt;
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
    end
  end

`ifdef SERIAL_LINK_RX_FIFO_IRQ_EN
  logic [15:0] r_thresh;
  logic        r_irq;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_thresh <= 16'(DEPTH / 2);
      r_irq    <= 1'b0;
    end else begin
      if (w_obi_wr && (w_reg == 2'd2)) begin
        if (bus.obi_be_i[0]) r_thresh[7:0]  <= bus.obi_wdata_i[7:0];
        if (bus.obi_be_i[1]) r_thresh[15:8] <= bus.obi_wdata_i[15:8];
      end
      r_irq <= (r_thresh != 16'd0) && (17'(r_count) >= {1'b0, r_thresh});
    end
  end

  assign w_thresh = r_thresh;
  assign irq_o    = r_irq;
  assign w_unused = ^{bus.obi_addr_i[ADDR_WIDTH-1:4], bus.obi_addr_i[1:0],
                      bus.obi_wdata_i[DATA_WIDTH-1:16]};
`else
  assign w_thresh = 16'd0;
  assign irq_o    = 1'b0;
  assign w_unused = ^{bus.obi_addr_i[ADDR_WIDTH-1:4], bus.obi_addr_i[1:0], bus.obi_wdata_i};
`endif

endmodule

// File: tb/tb_serial_link_rx_fifo.sv
// Bench for serial_link_rx_fifo: register vectors, FIFO corner sequences, random traffic vs a queue model.
module tb_serial_link_rx_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
`ifdef SERIAL_LINK_RX_FIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clk_i;
  logic rst_ni;
  logic irq_o;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   b_cnt = 0;
  logic [31:0] q[$];
  bit   m_ovf = 1'b0;

  serial_link_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  serial_link_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus),
    .irq_o (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [11];

  function automatic logic [31:0] thr(input logic [31:0] v);
    return IRQ ? v : 32'h0;
  endfunction

  function automatic logic [31:0] st(input int cnt, input bit ovf);
    return (32'(cnt) << 8) | {29'd0, ovf, (cnt == DEPTH), (cnt == 0)};
  endfunction

  function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic obi_op(input logic we, input logic [1:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    @(posedge clk_i); #1;
    bus.obi_req_i = 1'b1; bus.obi_we_i = we; bus.obi_addr_i = {28'h0, a, 2'b00};
    bus.obi_be_i = 4'hf; bus.obi_wdata_i = wd;
    #1; check("obi_gnt", 32'(bus.obi_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    bus.obi_req_i = 1'b0; bus.obi_we_i = 1'b0;
    check("obi_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
    rd = bus.obi_rdata_o;
  endtask

  task automatic status_chk(input string nm, input logic [31:0] exp);
    logic [31:0] rd;
    obi_op(1'b0, 2'd1, 32'h0, rd);
    check(nm, rd, exp);
  endtask

  task automatic axi_wr(input logic [31:0] d, input logic [3:0] s);
    bit acc = 1'b0;
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = d; bus.w_strb_i = s;
    bus.b_ready_i = 1'b1;
    for (int i = 0; i < 16 && !acc; i++) begin
      #1;
      if (bus.aw_ready_o && bus.w_ready_o) acc = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("aw_accept", 32'(acc), 32'd1);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) begin
      if (bus.b_valid_o) acc = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("b_valid", 32'(acc), 32'd1);
    check("b_resp", 32'(bus.b_resp_o), 32'd0);
    if (acc) b_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic ovf_try(input logic [31:0] d);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = d; bus.w_strb_i = 4'hf;
    #1; check("full_w_ready", 32'(bus.w_ready_o), 32'd0);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    rst_ni = 1'b0;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.w_data_i = '0; bus.w_strb_i = '0;
    bus.b_ready_i = 1'b1; bus.obi_req_i = 1'b0; bus.obi_we_i = 1'b0; bus.obi_addr_i = '0;
    bus.obi_be_i = '0; bus.obi_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_aw_ready", 32'(bus.aw_ready_o), 32'd0);
    check("rst_w_ready", 32'(bus.w_ready_o), 32'd0);
    check("rst_b_valid", 32'(bus.b_valid_o), 32'd0);
    check("rst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
    check("rst_rdata", bus.obi_rdata_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    #1; check("idle_aw_ready", 32'(bus.aw_ready_o), 32'd1);

    // Register-map vectors on an empty FIFO
    vt[0]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0001};
    vt[1]  = '{1'b0, 2'd2, 32'h0, thr(32'd4)};
    vt[2]  = '{1'b1, 2'd2, 32'h5, 32'h0};
    vt[3]  = '{1'b0, 2'd2, 32'h0, thr(32'd5)};
    vt[4]  = '{1'b0, 2'd0, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0001};
    vt[6]  = '{1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0};
    vt[7]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    vt[8]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0001};
    vt[9]  = '{1'b1, 2'd2, 32'h4, 32'h0};
    vt[10] = '{1'b0, 2'd2, 32'h0, thr(32'd4)};
    for (int i = 0; i < 11; i++) begin
      obi_op(vt[i].we, vt[i].a, vt[i].wd, rd);
      check($sformatf("vec%0d", i), rd, vt[i].exp);
    end

    // Fill to full, then overflow attempt racing a CLEAR write
    for (int i = 1; i <= 8; i++) begin
      axi_wr(32'(i * 32'h11), 4'hf);
      q.push_back(32'(i * 32'h11));
    end
    check("b_count", 32'(b_cnt), 32'd8);
    status_chk("status_full", 32'h0000_0802);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = 32'h99; bus.w_strb_i = 4'hf;
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b1; bus.obi_addr_i = 32'hC;
    #1;
    check("ninth_w_ready", 32'(bus.w_ready_o), 32'd0);
    check("ninth_aw_ready", 32'(bus.aw_ready_o), 32'd0);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.obi_req_i = 1'b0; bus.obi_we_i = 1'b0;
    status_chk("ovf_set_beats_clr", 32'h0000_0806);

    // Pop from full while a write waits: push lands only the cycle after
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = 32'h99;
    bus.obi_req_i = 1'b1; bus.obi_addr_i = 32'h0;
    #1; check("pop_full_w_ready", 32'(bus.w_ready_o), 32'd0);
    @(posedge clk_i); #1;
    bus.obi_req_i = 1'b0;
    check("pop_full_rdata", bus.obi_rdata_o, q.pop_front());
    #1; check("after_pop_w_ready", 32'(bus.w_ready_o), 32'd1);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    q.push_back(32'h99);
    check("late_push_b_valid", 32'(bus.b_valid_o), 32'd1);
    @(posedge clk_i); #1;
    status_chk("status_still_8", 32'h0000_0806);
    obi_op(1'b1, 2'd3, 32'h0, rd);
    status_chk("status_cleared", 32'h0000_0802);
    while (q.size() > 0) begin
      obi_op(1'b0, 2'd0, 32'h0, rd);
      check("drain", rd, q.pop_front());
    end
    status_chk("status_drained", 32'h0000_0001);

    // Strobe masking with a DATA read the cycle after acceptance
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = 32'hAABB_CCDD; bus.w_strb_i = 4'b0101;
    #1; check("strb_aw_ready", 32'(bus.aw_ready_o), 32'd1);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    bus.obi_req_i = 1'b1; bus.obi_addr_i = 32'h0;
    @(posedge clk_i); #1;
    bus.obi_req_i = 1'b0;
    check("strb_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
    check("strb_rdata", bus.obi_rdata_o, 32'h00BB_00DD);
    status_chk("strb_empty", 32'h0000_0001);

    // Threshold interrupt timing
    obi_op(1'b1, 2'd2, 32'd3, rd);
    axi_wr(32'h1, 4'hf); axi_wr(32'h2, 4'hf);
    check("irq_two", 32'(irq_o), 32'd0);
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = 32'h3; bus.w_strb_i = 4'hf;
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    check("irq_at_push", 32'(irq_o), 32'd0);
    @(posedge clk_i); #1;
    check("irq_rise", 32'(irq_o), 32'(IRQ));
    obi_op(1'b0, 2'd0, 32'h0, rd);
    check("irq_pop_data", rd, 32'h1);
    check("irq_hold", 32'(irq_o), 32'(IRQ));
    @(posedge clk_i); #1;
    check("irq_fall", 32'(irq_o), 32'd0);
    obi_op(1'b0, 2'd0, 32'h0, rd); check("irq_drain2", rd, 32'h2);
    obi_op(1'b0, 2'd0, 32'h0, rd); check("irq_drain3", rd, 32'h3);
    obi_op(1'b1, 2'd2, 32'd0, rd);
    axi_wr(32'h5A, 4'hf);
    repeat (2) @(posedge clk_i);
    #1; check("irq_thresh0", 32'(irq_o), 32'd0);
    obi_op(1'b0, 2'd0, 32'h0, rd); check("thresh0_data", rd, 32'h5A);
    obi_op(1'b1, 2'd2, 32'd4, rd);

    // Random traffic against the queue model
    m_ovf = 1'b0;
    for (int it = 0; it < 300; it++) begin
      int op;
      logic [31:0] d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        d = $urandom();
        if (q.size() < DEPTH) begin
          s = 4'($urandom_range(0, 15));
          axi_wr(d, s);
          q.push_back(mask(d, s));
        end else begin
          ovf_try(d);
          m_ovf = 1'b1;
        end
      end else if (op <= 6) begin
        obi_op(1'b0, 2'd0, 32'h0, rd);
        if (q.size() > 0) check("rnd_pop", rd, q.pop_front());
        else check("rnd_pop_empty", rd, 32'h0);
      end else if (op == 7) begin
        status_chk("rnd_status", st(q.size(), m_ovf));
      end else if (op == 8) begin
        obi_op(1'b1, 2'd3, 32'h0, rd);
        m_ovf = 1'b0;
        check("rnd_clr_rdata", rd, 32'h0);
      end else begin
        obi_op(1'b1, 2'd0, $urandom(), rd);
        check("rnd_wdata_rdata", rd, 32'h0);
      end
    end
    status_chk("rnd_final_status", st(q.size(), m_ovf));
    while (q.size() > 0) begin
      obi_op(1'b0, 2'd0, 32'h0, rd);
      check("rnd_drain", rd, q.pop_front());
    end

    // Reset with a pending B response and an in-flight OBI read
    for (int i = 0; i < 4; i++) axi_wr(32'(i), 4'hf);
    @(posedge clk_i); #1;
    bus.b_ready_i = 1'b0;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_data_i = 32'h55; bus.w_strb_i = 4'hf;
    @(posedge clk_i); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    check("b_pending", 32'(bus.b_valid_o), 32'd1);
    status_chk("status_five", st(5, 1'b0));
    check("b_hold", 32'(bus.b_valid_o), 32'd1);
    rst_ni = 1'b0;
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_addr_i = 32'h4;
    #1; check("rdy_in_rst", 32'(bus.aw_ready_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; bus.obi_req_i = 1'b0; bus.b_ready_i = 1'b1;
    check("rst_b_drop", 32'(bus.b_valid_o), 32'd0);
    check("rst_rvalid_drop", 32'(bus.obi_rvalid_o), 32'd0);
    check("rst_rdata_zero", bus.obi_rdata_o, 32'h0);
    status_chk("rst_status", 32'h0000_0001);
    obi_op(1'b0, 2'd2, 32'h0, rd);
    check("rst_thresh", rd, thr(32'd4));
    check("rst_irq_low", 32'(irq_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
